morse_sequencer: RTL
====================

# morse_sequencer

Parametrised Morse-code LED sequencer for the puzzle IO panel: it takes a packed symbol string, latches it on a start pulse and blinks it out on one LED using standard Morse unit timing.
- Timing ratios: dot 1 unit on, dash 3 units on, 1-unit gap after each element, 3-unit letter gap.
- Unit length, maximum word length and optional continuous repeat are configurable.
- It sits between the module-select/game controller, which drives `seq_in` and `start`, and the physical LED pin.

## Interface
Parameters:
- `UNIT_CYCLES`, default 10000: clock cycles per Morse unit; legal range ≥1.
- `MAX_SYMS`, default 32: symbol slots in `seq_in`; legal range ≥2.

Ports (all outputs registered):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `stop`  in  1  abort request; valid in any state.
- `seq_in`  in  2*MAX_SYMS  packed symbol string; symbol k occupies bits [2k+1:2k], so symbol 0 is sent first.
- `morse_led`  out  1  LED drive; high only in ON.
- `busy`  out  1  high from the cycle after `start` is accepted until return to IDLE.
- `done`  out  1  one-cycle pulse when the word completes normally.
- `sym_idx`  out  $clog2(MAX_SYMS)  index of the current symbol.

## Operation
Symbol codes:
- 00: dot.
- 01: dash.
- 10: letter gap.
- 11: end of word.

States: IDLE, FETCH, ON, GAP, WORD_GAP (WORD_GAP exists only with the macro).
- **IDLE**
  - Condition: `start`=1 and `stop`=0.
  - Action: latch `seq_in` into an internal register; set `sym_idx`=0 and `busy`=1.
  - Next state: FETCH.
  - `seq_in` is ignored at all other times.
- **FETCH** (always one cycle), decodes the symbol at `sym_idx`:
  - 00: go to ON, counter = UNIT_CYCLES-1, `morse_led`←1.
  - 01: go to ON, counter = 3*UNIT_CYCLES-1, `morse_led`←1.
  - 10: go to GAP, counter = 2*UNIT_CYCLES-1. Together with the preceding element gap this gives 3 units.
  - 11: end of word (see below).
- **ON**: counter decrements each cycle. At 0: go to GAP, counter = UNIT_CYCLES-1, `morse_led`←0.
- **GAP**: counter decrements each cycle. At 0:
  - If `sym_idx`=MAX_SYMS-1: end of word.
  - Otherwise: `sym_idx`+1, go to FETCH.
- **End of word**:
  - Without the macro: IDLE, `busy`←0, `done`←1 for one cycle.
  - With the macro: see Configuration.
- Counter width is $clog2(7*UNIT_CYCLES). Dash and word-gap loads must not truncate.
- `stop`=1 in any state other than IDLE:
  - Next edge: IDLE, `morse_led`=0, `busy`=0.
  - No `done` pulse.
  - `stop` has priority over every other transition.
- `start` while `busy`=1 is ignored. `start` and `stop` asserted together in IDLE: stay in IDLE.
- A first symbol of 11 gives a zero-length word: FETCH → IDLE, `done` pulses, LED never lights.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; `morse_led`=0, `busy`=0, `done`=0, `sym_idx`=0; counter 0.
  - Reset overrides `start` and `stop` and acts mid-symbol.
- `start` sampled at edge E0: FETCH at E0, `morse_led` high from E1.
- Per-symbol length including the FETCH cycle, in cycles:
  - Dot: UNIT_CYCLES+UNIT_CYCLES+1.
  - Dash: 3*UNIT_CYCLES+UNIT_CYCLES+1.
  - Letter gap: 2*UNIT_CYCLES+1.
  - End code: 1 cycle, then `done` is high for exactly one cycle.
- `done` and `busy` fall together: `done` goes high on the same edge `busy` goes low.

## Configuration
- Macro: `MORSE_REPEAT_EN`.
- Defined: at end of word, go to WORD_GAP instead of IDLE.
  - WORD_GAP: counter = 7*UNIT_CYCLES-1, LED low.
  - At 0: `sym_idx`←0, go to FETCH, and the latched word replays.
  - `done` pulses on entry to WORD_GAP on every pass; `busy` stays high.
  - Only `stop` or reset leaves the loop.
  - A zero-length word (first code 11) goes directly to IDLE with `done` and does not loop.
- Undefined: WORD_GAP logic absent; the block returns to IDLE after one pass.

## Test plan
All scenarios use UNIT_CYCLES=4 and MAX_SYMS=8.
1. Letter "A":
   - Stimulus: `seq_in`[5:0]=6'b11_01_00, `start` at E0.
   - LED high over E1–E5 (4 cycles), low E5–E10, high E10–E22 (12 cycles).
   - `done` high E27–E28; `busy` low from E27.
2. Letter gap:
   - Stimulus: `seq_in`[5:0]=6'b11_10_00.
   - LED dot over E1–E5.
   - No LED activity E5–E18; `done` at E19.
3. Full string with no end code:
   - Stimulus: eight dots, no 11 code.
   - `sym_idx` reaches 7; after the last gap `done` pulses and `sym_idx` returns to 0 at the next start.
4. Abort and ignored start:
   - `stop` mid-dash (E14) → IDLE at E15, LED 0, no `done`.
   - `start` during `busy` has no effect.
   - `start`+`stop` together in IDLE → stays idle.
5. Mid-operation reset:
   - `reset`=0 at E12 while the LED is on.
   - Next cycle all outputs are 0; `start` still asserted during reset is not accepted.
6. `MORSE_REPEAT_EN`, "A":
   - `done` pulses at E27, LED low 28 cycles, dot restarts at E56 (`sym_idx`=0).
   - `stop` ends the loop.

Source files
------------

// File: rtl/morse_sequencer_if.sv
`default_nettype none
`timescale 1ns / 1ps
// +----------------------------------------------------------------------------+
// | morse_sequencer_if : controller <-> Morse sequencer handshake bundle.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface morse_sequencer_if #(
  parameter int MAX_SYMS = 32
);
  localparam int IDX_W = $clog2(MAX_SYMS);

  logic                  start;
  logic                  stop;
  logic [2*MAX_SYMS-1:0] seq_in;
  logic                  morse_led;
  logic                  busy;
  logic                  done;
  logic [IDX_W-1:0]      sym_idx;

  modport master (
    output start, stop, seq_in,
    input  morse_led, busy, done, sym_idx
  );

  modport slave (
    input  start, stop, seq_in,
    output morse_led, busy, done, sym_idx
  );
endinterface
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
`timescale 1ns / 1ps
// +----------------------------------------------------------------------------+
// | morse_sequencer : latches a packed symbol word and blinks it as Morse.     |
// | Optional macro MORSE_REPEAT_EN replays the word forever. Rev 1.0           |
// +----------------------------------------------------------------------------+
module morse_sequencer #(
  parameter int UNIT_CYCLES = 10000,
  parameter int MAX_SYMS    = 32
) (
  input  logic               clk,
  input  logic               reset,
  morse_sequencer_if.slave   bus
);

  localparam int CNT_W = $clog2(7 * UNIT_CYCLES);
  localparam int IDX_W = $clog2(MAX_SYMS);

  localparam logic [CNT_W-1:0] c_dot_load  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_dash_load = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_lgap_load = CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(MAX_SYMS - 1);
`ifdef MORSE_REPEAT_EN
  localparam logic [CNT_W-1:0] c_wgap_load = CNT_W'(7 * UNIT_CYCLES - 1);
`endif

  localparam logic [1:0] c_sym_dot  = 2'b00;
  localparam logic [1:0] c_sym_dash = 2'b01;
  localparam logic [1:0] c_sym_lgap = 2'b10;

`ifdef MORSE_REPEAT_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ON       = 3'd2,
    S_GAP      = 3'd3,
    S_WORD_GAP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ON    = 3'd2,
    S_GAP   = 3'd3
  } state_t;
`endif

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic [MAX_SYMS-1:0][1:0]    r_word;
  logic [IDX_W-1:0]            r_sym_idx;
  logic                        r_led;
  logic                        r_busy;
  logic                        r_done;

  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [IDX_W-1:0]            w_idx_nxt;
  logic                        w_led_nxt;
  logic                        w_busy_nxt;
  logic                        w_done_nxt;
  logic                        w_load;
  logic                        w_end_word;
  logic [1:0]                  w_sym;
  logic                        w_cnt_zero;

  assign w_sym      = r_word[r_sym_idx];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_word    <= '0;
      r_sym_idx <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sym_idx <= w_idx_nxt;
      r_led     <= w_led_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      if (w_load) begin
        r_word <= bus.seq_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_sym_idx;
    w_led_nxt   = r_led;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_end_word  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_sym == c_sym_dot) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = c_dot_load;
          w_led_nxt   = 1'b1;
        end else if (w_sym == c_sym_dash) begin
          w_state_nxt = S_ON;
          w_cnt_nxt   = c_dash_load;
          w_led_nxt   = 1'b1;
        end else if (w_sym == c_sym_lgap) begin
          // The preceding element gap supplies the third unit of silence.
          w_state_nxt = S_GAP;
          w_cnt_nxt   = c_lgap_load;
        end else begin
          w_end_word  = 1'b1;
        end
      end
      S_ON: begin
        if (w_cnt_zero) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = c_dot_load;
          w_led_nxt   = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end
      S_GAP: begin
        if (w_cnt_zero) begin
          if (r_sym_idx == c_last_idx) begin
            w_end_word  = 1'b1;
          end else begin
            w_idx_nxt   = r_sym_idx + IDX_W'(1);
            w_state_nxt = S_FETCH;
          end
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end
`ifdef MORSE_REPEAT_EN
      S_WORD_GAP: begin
        if (w_cnt_zero) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_FETCH;
        end else begin
          w_cnt_nxt   = r_cnt - c_cnt_one;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_led_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    if (w_end_word) begin
      w_done_nxt = 1'b1;
      w_led_nxt  = 1'b0;
`ifdef MORSE_REPEAT_EN
      // An empty word (end code in slot 0) would spin forever, so it exits.
      if (r_state == S_FETCH && r_sym_idx == '0) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end else begin
        w_state_nxt = S_WORD_GAP;
        w_cnt_nxt   = c_wgap_load;
      end
`else
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b0;
`endif
    end

    if (bus.stop && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_led_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  assign bus.morse_led = r_led;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sym_idx   = r_sym_idx;

endmodule
`default_nettype wire
